// File: rtl/render_sched.sv
`default_nettype none
// ============================================================================
// Module      : render_sched
// Description : Frame render scheduler. On an accepted frame_start it clears
//               the framebuffer to a background colour, then walks the sprite
//               table and launches render_tile once per valid entry, passing
//               its framebuffer writes through while it runs. A per-tile
//               watchdog aborts tiles that never finish.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               frame_start         - one-cycle frame request (ignored if busy)
//               bg_color            - clear colour, latched on accept
//               obj_idx / obj_entry - sprite-table read (1-cycle latency)
//               tile_rst            - render_tile reset, low while a tile runs
//               tile_id/top/left    - tile parameters for render_tile
//               tile_finish         - render_tile completion level
//               tile_dst_*          - render_tile framebuffer write port
//               fb_*                - framebuffer write port (frame RAM port A)
//               busy, frame_done, timeout_err - status
// Revision    : 1.0 - initial release
// ============================================================================
module render_sched #(
    parameter int N_OBJ        = 16,
    parameter int FB_WORDS     = 307200,
    parameter int TILE_TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    input  logic [15:0]               bg_color,
    output logic [$clog2(N_OBJ)-1:0]  obj_idx,
    input  logic [31:0]               obj_entry,
    output logic                      tile_rst,
    output logic [7:0]                tile_id,
    output logic [9:0]                tile_top,
    output logic [9:0]                tile_left,
    input  logic                      tile_finish,
    input  logic [18:0]               tile_dst_addr,
    input  logic [15:0]               tile_dst_data,
    input  logic                      tile_dst_wr,
    output logic [18:0]               fb_addr,
    output logic [15:0]               fb_data,
    output logic                      fb_wr,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      timeout_err
);

    localparam int c_IDX_W = $clog2(N_OBJ);
    localparam int c_TMO_W = $clog2(TILE_TIMEOUT + 1);

    localparam logic [18:0]        c_FB_LAST  = 19'(FB_WORDS - 1);
    localparam logic [18:0]        c_FB_ONE   = 19'd1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_OBJ - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TILE_TIMEOUT - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_FETCH  = 3'd2,
        S_CHECK  = 3'd3,
        S_LAUNCH = 3'd4,
        S_WAIT   = 3'd5,
        S_NEXT   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_accept;
    logic                 w_timeout;

    logic [15:0]          r_bg;
    logic [18:0]          r_clr_cnt;
    logic [c_IDX_W-1:0]   r_obj_idx;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic [7:0]           r_tile_id;
    logic [9:0]           r_tile_top;
    logic [9:0]           r_tile_left;
    logic                 r_tile_rst;
    logic                 r_busy;
    logic                 r_frame_done;
    logic                 r_timeout_err;

    // Reserved sprite-entry bits carry no meaning here.
    logic                 w_unused_rsvd;
    assign w_unused_rsvd = ^obj_entry[22:20];

    // ------------------------------------------------------------------
    // Next-state and framebuffer write mux
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_timeout = 1'b0;
        fb_wr     = 1'b0;
        fb_addr   = 19'd0;
        fb_data   = 16'd0;

        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_next   = S_CLEAR;
                    w_accept = 1'b1;
                end
            end
            S_CLEAR: begin
                fb_wr   = 1'b1;
                fb_addr = r_clr_cnt;
                fb_data = r_bg;
                if (r_clr_cnt == c_FB_LAST) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next = S_CHECK;
            end
            S_CHECK: begin
                w_next = obj_entry[31] ? S_LAUNCH : S_NEXT;
            end
            S_LAUNCH: begin
                fb_addr = tile_dst_addr;
                fb_data = tile_dst_data;
                fb_wr   = tile_dst_wr & ~r_tile_rst;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                fb_addr = tile_dst_addr;
                fb_data = tile_dst_data;
                fb_wr   = tile_dst_wr & ~r_tile_rst;
                // Completion wins over a coincident watchdog expiry.
                if (tile_finish) begin
                    w_next = S_NEXT;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_next    = S_NEXT;
                    w_timeout = 1'b1;
                end
            end
            S_NEXT: begin
                w_next = (r_obj_idx == c_IDX_LAST) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers. Status outputs are derived from the
    // next state so they change on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_bg          <= 16'd0;
            r_clr_cnt     <= 19'd0;
            r_obj_idx     <= '0;
            r_tmo_cnt     <= '0;
            r_tile_id     <= 8'd0;
            r_tile_top    <= 10'd0;
            r_tile_left   <= 10'd0;
            r_tile_rst    <= 1'b1;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_busy       <= (w_next != S_IDLE);
            r_frame_done <= (w_next == S_DONE);
            r_tile_rst   <= !((w_next == S_LAUNCH) || (w_next == S_WAIT));

            if (w_accept) begin
                r_bg          <= bg_color;
                r_clr_cnt     <= 19'd0;
                r_obj_idx     <= '0;
                r_timeout_err <= 1'b0;
            end

            // Counter holds at the last address rather than wrapping.
            if ((r_state == S_CLEAR) && (r_clr_cnt != c_FB_LAST)) begin
                r_clr_cnt <= r_clr_cnt + c_FB_ONE;
            end

            if ((r_state == S_CHECK) && obj_entry[31]) begin
                r_tile_id   <= obj_entry[30:23];
                r_tile_top  <= obj_entry[19:10];
                r_tile_left <= obj_entry[9:0];
            end

            if (r_state == S_LAUNCH) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + c_TMO_ONE;
            end

            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end

            if ((r_state == S_NEXT) && (r_obj_idx != c_IDX_LAST)) begin
                r_obj_idx <= r_obj_idx + c_IDX_ONE;
            end
        end
    end

    assign obj_idx     = r_obj_idx;
    assign tile_rst    = r_tile_rst;
    assign tile_id     = r_tile_id;
    assign tile_top    = r_tile_top;
    assign tile_left   = r_tile_left;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_render_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_render_sched
// Description : Directed self-checking bench for render_sched with a small
//               sprite table, a render_tile model and framebuffer monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_render_sched;

    localparam int c_N_OBJ = 4;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [15:0] bg_color;
    logic [1:0]  obj_idx;
    logic [31:0] obj_entry;
    logic        tile_rst;
    logic [7:0]  tile_id;
    logic [9:0]  tile_top;
    logic [9:0]  tile_left;
    logic        tile_finish;
    logic [18:0] tile_dst_addr;
    logic [15:0] tile_dst_data;
    logic        tile_dst_wr;
    logic [18:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_wr;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;

    render_sched #(
        .N_OBJ        (c_N_OBJ),
        .FB_WORDS     (16),
        .TILE_TIMEOUT (32)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .bg_color      (bg_color),
        .obj_idx       (obj_idx),
        .obj_entry     (obj_entry),
        .tile_rst      (tile_rst),
        .tile_id       (tile_id),
        .tile_top      (tile_top),
        .tile_left     (tile_left),
        .tile_finish   (tile_finish),
        .tile_dst_addr (tile_dst_addr),
        .tile_dst_data (tile_dst_data),
        .tile_dst_wr   (tile_dst_wr),
        .fb_addr       (fb_addr),
        .fb_data       (fb_data),
        .fb_wr         (fb_wr),
        .busy          (busy),
        .frame_done    (frame_done),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite table with one cycle of read latency.
    logic [31:0] tbl [c_N_OBJ];
    always @(posedge clk) obj_entry <= tbl[obj_idx];

    // render_tile model: 4 writes at 0x100+n from release, finishes 10 cycles
    // after release unless tile_id is 1 (never finishes). When junk_en is set
    // it also writes to 0x300 while held in reset.
    int   tcnt;
    logic junk_en;
    always @(posedge clk) begin
        if (tile_rst) tcnt <= 0;
        else          tcnt <= tcnt + 1;
    end
    assign tile_finish   = !tile_rst && (tile_id != 8'd1) && (tcnt >= 10);
    assign tile_dst_wr   = (!tile_rst && (tcnt < 4)) || (junk_en && tile_rst);
    assign tile_dst_addr = tile_rst ? 19'h00300 : (19'h00100 + 19'(tcnt));
    assign tile_dst_data = 16'hA000 + 16'(tcnt);

    // Event monitor
    int          n_done, n_fbwr, n_tilewr, n_junk, n_low, n_launch;
    logic        prev_trst;
    logic [7:0]  cap_id;
    logic [9:0]  cap_top, cap_left;
    initial begin
        n_done = 0; n_fbwr = 0; n_tilewr = 0; n_junk = 0; n_low = 0; n_launch = 0;
        prev_trst = 1'b1; cap_id = 0; cap_top = 0; cap_left = 0;
    end
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_done) n_done++;
            if (fb_wr) n_fbwr++;
            if (fb_wr && fb_addr[18:8] == 11'd1) n_tilewr++;
            if (fb_wr && fb_addr[18:8] == 11'd3) n_junk++;
            if (!tile_rst) n_low++;
            if (prev_trst && !tile_rst) begin
                n_launch++;
                cap_id = tile_id; cap_top = tile_top; cap_left = tile_left;
            end
        end
        prev_trst = tile_rst;
    end

    int n_vec, n_bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [15:0] color);
        bg_color = color;
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 400 && busy; k++) @(negedge clk);
        check(tag, {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_launch(input string tag);
        @(negedge clk);
        for (int k = 0; k < 200 && tile_rst; k++) @(negedge clk);
        check(tag, {63'd0, tile_rst}, 64'd0);
    endtask

    // {tile_rst, fb_wr, busy, frame_done, timeout_err, obj_idx, id, top, left}
    function automatic logic [63:0] rst_vec();
        return 64'({tile_rst, fb_wr, busy, frame_done, timeout_err, obj_idx,
                    tile_id, tile_top, tile_left});
    endfunction
    localparam logic [63:0] c_RST_EXP = 64'h4_0000_0000;

    int b_done, b_fbwr, b_tilewr, b_junk, b_low, b_launch;
    task automatic snap();
        b_done = n_done; b_fbwr = n_fbwr; b_tilewr = n_tilewr;
        b_junk = n_junk; b_low = n_low; b_launch = n_launch;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_bad = 0;
        rst = 1'b1; frame_start = 1'b0; bg_color = 16'd0; junk_en = 1'b0;
        for (int i = 0; i < c_N_OBJ; i++) tbl[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", rst_vec(), c_RST_EXP);

        // ---- Clear only, all entries invalid ----
        snap();
        start_frame(16'hF00F);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("clear_%0d", i), 64'({fb_wr, fb_addr, fb_data}),
                  64'({1'b1, 19'(i), 16'hF00F}));
        end
        @(negedge clk);
        check("clear_end_wr", {63'd0, fb_wr}, 64'd0);
        wait_idle("clear_idle");
        check("clear_done_cnt", 64'(n_done - b_done), 64'd1);
        check("clear_fbwr_cnt", 64'(n_fbwr - b_fbwr), 64'd16);
        check("clear_no_launch", 64'(n_launch - b_launch), 64'd0);

        // ---- Single tile on entry 1 ----
        tbl[1] = {1'b1, 8'd5, 3'b000, 10'd20, 10'd30};
        snap();
        start_frame(16'h1234);
        wait_idle("tile_idle");
        check("tile_launch_cnt", 64'(n_launch - b_launch), 64'd1);
        check("tile_params", 64'({cap_id, cap_top, cap_left}),
              64'({8'd5, 10'd20, 10'd30}));
        check("tile_low_cycles", 64'(n_low - b_low), 64'd11);
        check("tile_writes", 64'(n_tilewr - b_tilewr), 64'd4);
        check("tile_done_cnt", 64'(n_done - b_done), 64'd1);
        check("tile_no_tmo", {63'd0, timeout_err}, 64'd0);

        // ---- Timeout on entry 0, entry 2 still rendered ----
        tbl[0] = {1'b1, 8'd1, 3'b000, 10'd0, 10'd0};
        tbl[1] = 32'd0;
        tbl[2] = {1'b1, 8'd7, 3'b000, 10'd3, 10'd4};
        snap();
        start_frame(16'h0000);
        wait_idle("tmo_idle");
        check("tmo_err", {63'd0, timeout_err}, 64'd1);
        check("tmo_launch_cnt", 64'(n_launch - b_launch), 64'd2);
        check("tmo_low_cycles", 64'(n_low - b_low), 64'd44);
        check("tmo_last_params", 64'({cap_id, cap_top, cap_left}),
              64'({8'd7, 10'd3, 10'd4}));
        check("tmo_done_cnt", 64'(n_done - b_done), 64'd1);

        // ---- Collisions: frame_start while busy, junk tile writes ----
        tbl[0] = 32'd0;
        tbl[2] = 32'd0;
        tbl[3] = {1'b1, 8'd9, 3'b000, 10'd1, 10'd2};
        junk_en = 1'b1;
        snap();
        start_frame(16'h5A5A);
        check("col_tmo_cleared", {63'd0, timeout_err}, 64'd0);
        repeat (4) @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        wait_launch("col_launch_seen");
        @(posedge clk); #1 frame_start = 1'b1;
        repeat (2) @(posedge clk);
        #1 frame_start = 1'b0;
        wait_idle("col_idle");
        repeat (20) @(negedge clk);
        check("col_stay_idle", {63'd0, busy}, 64'd0);
        check("col_done_cnt", 64'(n_done - b_done), 64'd1);
        check("col_fbwr_cnt", 64'(n_fbwr - b_fbwr), 64'd20);
        check("col_junk_blocked", 64'(n_junk - b_junk), 64'd0);
        check("col_launch_cnt", 64'(n_launch - b_launch), 64'd1);
        junk_en = 1'b0;

        // ---- Reset mid-CLEAR ----
        start_frame(16'hBEEF);
        for (int k = 0; k < 40 && !(fb_wr && fb_addr == 19'd7); k++) @(negedge clk);
        check("rstc_at_addr7", 64'({fb_wr, fb_addr}), 64'({1'b1, 19'd7}));
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstc_state", rst_vec(), c_RST_EXP);
        snap();
        repeat (10) @(negedge clk);
        check("rstc_no_resume", 64'({busy, n_fbwr - b_fbwr}), 64'd0);

        // ---- Restart, then reset mid-WAIT ----
        tbl[3] = 32'd0;
        tbl[0] = {1'b1, 8'd2, 3'b000, 10'd11, 10'd12};
        start_frame(16'h0F0F);
        @(negedge clk);
        check("restart_addr0", 64'({fb_wr, fb_addr, fb_data}),
              64'({1'b1, 19'd0, 16'h0F0F}));
        wait_launch("rstw_launch_seen");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstw_state", rst_vec(), c_RST_EXP);
        repeat (20) @(negedge clk);
        check("rstw_no_resume", 64'({busy, tile_rst, fb_wr}), 64'({1'b0, 1'b1, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
